// File: rtl/frame_source_arbiter.sv
// Round-robin frame arbiter: grants one pixel source for a whole frame and
// streams its pixels to the display controller one request at a time.
module frame_source_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int PIXEL_W    = 16,
    parameter int RESOLUTION = 100,
    localparam int IDX_W     = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1,
    localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         src_req,
    input  logic [NUM_SRC*PIXEL_W-1:0] src_pixel,
    output logic [NUM_SRC-1:0]         src_grant,
    output logic                       src_pix_rd,
    output logic                       src_frame_end,
    input  logic                       disp_pix_req,
    output logic [PIXEL_W-1:0]         disp_pixel,
    output logic                       disp_frame_done,
    output logic [IDX_W-1:0]           pixel_index
);

    typedef enum logic [1:0] {IDLE, ARB, STREAM, DONE} state_t;

    localparam logic [NUM_SRC-1:0] GRANT_LSB = NUM_SRC'(1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(RESOLUTION - 1);

    state_t               state_reg, state_next;
    logic [NUM_SRC-1:0]   grant_reg;
    logic [SRC_W-1:0]     grant_idx_reg;
    logic [SRC_W-1:0]     last_grant_reg;
    logic                 src_pix_rd_reg;
    logic                 frame_end_reg;
    logic [PIXEL_W-1:0]   disp_pixel_reg;
    logic [IDX_W-1:0]     pixel_index_reg;

    logic                 pick_valid;
    logic [SRC_W-1:0]     pick_idx;
    logic [SRC_W-1:0]     cand_idx;
    logic                 last_pix;
    logic [PIXEL_W-1:0]   src_pix_arr [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign src_pix_arr[gi] = src_pixel[gi*PIXEL_W +: PIXEL_W];
        end
    endgenerate

    // Walk offsets from the far end so the nearest requester after last_grant wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand_idx = SRC_W'((int'(last_grant_reg) + k) % NUM_SRC);
            if (src_req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign last_pix = (pixel_index_reg == LAST_IDX);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|src_req) state_next = ARB;
            ARB:     state_next = pick_valid ? STREAM : IDLE;
            STREAM:  if (disp_pix_req && last_pix) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_reg       <= '0;
            grant_idx_reg   <= '0;
            last_grant_reg  <= SRC_W'(NUM_SRC - 1);
            src_pix_rd_reg  <= 1'b0;
            frame_end_reg   <= 1'b0;
            disp_pixel_reg  <= '0;
            pixel_index_reg <= '0;
        end else begin
            src_pix_rd_reg <= 1'b0;
            frame_end_reg  <= 1'b0;
            case (state_reg)
                ARB: begin
                    grant_reg     <= pick_valid ? (GRANT_LSB << pick_idx) : '0;
                    grant_idx_reg <= pick_idx;
                end
                STREAM: begin
                    if (disp_pix_req) begin
                        disp_pixel_reg  <= src_pix_arr[grant_idx_reg];
                        src_pix_rd_reg  <= 1'b1;
                        pixel_index_reg <= last_pix ? '0 : pixel_index_reg + 1'b1;
                    end
                end
                // Frame end is registered here so it lands after the last read pulse.
                DONE: begin
                    frame_end_reg  <= 1'b1;
                    grant_reg      <= '0;
                    last_grant_reg <= grant_idx_reg;
                end
                default: ;
            endcase
        end
    end

    assign src_grant       = grant_reg;
    assign src_pix_rd      = src_pix_rd_reg;
    assign src_frame_end   = frame_end_reg;
    assign disp_pixel      = disp_pixel_reg;
    assign pixel_index     = pixel_index_reg;
    assign disp_frame_done = (state_reg == IDLE);

endmodule

// File: tb/tb_frame_source_arbiter.sv
// Directed bench for frame_source_arbiter: grants and pixels are queued when
// driven and compared when the DUT presents them.
module tb_frame_source_arbiter;

    localparam int NUM_SRC    = 4;
    localparam int PIXEL_W    = 16;
    localparam int RESOLUTION = 4;
    localparam int IDX_W      = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_SRC-1:0]         src_req;
    logic [NUM_SRC*PIXEL_W-1:0] src_pixel;
    logic [NUM_SRC-1:0]         src_grant;
    logic                       src_pix_rd;
    logic                       src_frame_end;
    logic                       disp_pix_req;
    logic [PIXEL_W-1:0]         disp_pixel;
    logic                       disp_frame_done;
    logic [IDX_W-1:0]           pixel_index;

    int checks = 0;
    int errors = 0;
    logic [PIXEL_W-1:0] pix_q [$];
    logic [NUM_SRC-1:0] grant_q [$];
    logic [PIXEL_W-1:0] last_exp_pixel;

    frame_source_arbiter #(
        .NUM_SRC(NUM_SRC),
        .PIXEL_W(PIXEL_W),
        .RESOLUTION(RESOLUTION)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src_req(src_req),
        .src_pixel(src_pixel),
        .src_grant(src_grant),
        .src_pix_rd(src_pix_rd),
        .src_frame_end(src_frame_end),
        .disp_pix_req(disp_pix_req),
        .disp_pixel(disp_pixel),
        .disp_frame_done(disp_frame_done),
        .pixel_index(pixel_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(src_grant), 32'h0);
        chk({tag, "_pix_rd"}, 32'(src_pix_rd), 32'h0);
        chk({tag, "_frame_end"}, 32'(src_frame_end), 32'h0);
        chk({tag, "_disp_pixel"}, 32'(disp_pixel), 32'h0);
        chk({tag, "_pixel_index"}, 32'(pixel_index), 32'h0);
        chk({tag, "_frame_done"}, 32'(disp_frame_done), 32'h1);
    endtask

    task automatic arb_phase(input int gi);
        logic [NUM_SRC-1:0] one;
        logic [NUM_SRC-1:0] exp;
        one = 1;
        grant_q.push_back(one << gi);
        tick();
        chk("arb_grant_low", 32'(src_grant), 32'h0);
        chk("arb_frame_done", 32'(disp_frame_done), 32'h0);
        tick();
        exp = grant_q.pop_front();
        chk("grant", 32'(src_grant), 32'(exp));
        chk("grant_pix_rd", 32'(src_pix_rd), 32'h0);
        $display("frame grant=%b req=%b", src_grant, src_req);
    endtask

    task automatic stream_phase(input int gi, input int npix, input logic [NUM_SRC-1:0] req_after);
        logic [NUM_SRC-1:0] one;
        logic [PIXEL_W-1:0] exp;
        one = 1;
        for (int p = 0; p < npix; p++) begin
            src_pixel    = {$urandom, $urandom};
            disp_pix_req = 1'b1;
            pix_q.push_back(src_pixel[gi*PIXEL_W +: PIXEL_W]);
            tick();
            disp_pix_req = 1'b0;
            if (p == 0) src_req = req_after;
            chk("pix_rd", 32'(src_pix_rd), 32'h1);
            if (pix_q.size() == 0) begin
                chk("pix_queue_empty", 32'h1, 32'h0);
            end else begin
                exp = pix_q.pop_front();
                last_exp_pixel = exp;
                chk("disp_pixel", 32'(disp_pixel), 32'(exp));
            end
            chk("pixel_index", 32'(pixel_index), 32'((p + 1) % RESOLUTION));
            chk("stream_grant", 32'(src_grant), 32'(one << gi));
            chk("stream_frame_end", 32'(src_frame_end), 32'h0);
            $display("pixel src=%0d idx=%0d data=%h", gi, p, disp_pixel);
            if (p == 0) begin
                src_pixel = {$urandom, $urandom};
                tick();
                chk("gap_pix_rd", 32'(src_pix_rd), 32'h0);
                chk("gap_index", 32'(pixel_index), 32'h1);
                chk("gap_pixel_hold", 32'(disp_pixel), 32'(last_exp_pixel));
            end
        end
    endtask

    task automatic finish_phase();
        chk("done_frame_done", 32'(disp_frame_done), 32'h0);
        tick();
        chk("frame_end", 32'(src_frame_end), 32'h1);
        chk("end_pix_rd", 32'(src_pix_rd), 32'h0);
        chk("end_grant", 32'(src_grant), 32'h0);
        chk("end_frame_done", 32'(disp_frame_done), 32'h1);
        chk("end_index", 32'(pixel_index), 32'h0);
        $display("frame end");
    endtask

    task automatic run_frame(input int gi, input logic [NUM_SRC-1:0] req_after);
        arb_phase(gi);
        stream_phase(gi, RESOLUTION, req_after);
        finish_phase();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_outputs("reset");
    endtask

    initial begin
        rst          = 1'b1;
        src_req      = '0;
        src_pixel    = '0;
        disp_pix_req = 1'b0;
        last_exp_pixel = '0;
        do_reset();

        // Single frame from source 0.
        src_req = 4'b0001;
        run_frame(0, 4'b0001);
        src_req = 4'b0000;

        // Display requests in IDLE and ARB are ignored; ARB with no request returns to IDLE.
        src_req      = 4'b0010;
        disp_pix_req = 1'b1;
        tick();
        chk("idle_req_pix_rd", 32'(src_pix_rd), 32'h0);
        chk("idle_req_index", 32'(pixel_index), 32'h0);
        chk("idle_req_pixel", 32'(disp_pixel), 32'(last_exp_pixel));
        chk("arb_entry_done", 32'(disp_frame_done), 32'h0);
        src_req = 4'b0000;
        tick();
        disp_pix_req = 1'b0;
        chk("arb_req_pix_rd", 32'(src_pix_rd), 32'h0);
        chk("arb_req_index", 32'(pixel_index), 32'h0);
        chk("arb_req_pixel", 32'(disp_pixel), 32'(last_exp_pixel));
        chk("arb_empty_grant", 32'(src_grant), 32'h0);
        chk("arb_empty_done", 32'(disp_frame_done), 32'h1);

        // Round robin over all four sources from a fresh reset.
        do_reset();
        src_req = 4'b1111;
        for (int f = 0; f < NUM_SRC; f++) begin
            run_frame(f, 4'b1111);
        end
        src_req = 4'b0000;

        // Request dropped mid-frame: frame still completes.
        src_req = 4'b0100;
        run_frame(2, 4'b0000);
        tick();
        chk("drop_idle_done", 32'(disp_frame_done), 32'h1);
        chk("drop_idle_grant", 32'(src_grant), 32'h0);

        // Reset mid-frame aborts without a frame end.
        src_req = 4'b0001;
        arb_phase(0);
        stream_phase(0, 2, 4'b0001);
        rst = 1'b1;
        tick();
        chk_reset_outputs("abort");
        rst     = 1'b0;
        src_req = 4'b0000;
        tick();
        chk("abort_no_frame_end", 32'(src_frame_end), 32'h0);
        chk("abort_idle_done", 32'(disp_frame_done), 32'h1);
        src_req = 4'b0010;
        run_frame(1, 4'b0010);
        src_req = 4'b0000;

        // Bring last_grant to 0, then 0011 must go to source 1, then 0001 to source 0.
        src_req = 4'b0001;
        run_frame(0, 4'b0000);
        src_req = 4'b0011;
        run_frame(1, 4'b0001);
        run_frame(0, 4'b0001);
        src_req = 4'b0000;
        tick();
        chk("final_idle_done", 32'(disp_frame_done), 32'h1);
        chk("queues_drained", 32'(pix_q.size() + grant_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
